// File: rtl/mem_port_arbiter_if.sv
// Bundle of request, response and shared memory-port signals for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the caches/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic [DATA_W-1:0]     inst_rdata;
  logic                  inst_data_ok;

  logic                  data_req;
  logic [DATA_W/8-1:0]   data_wen;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W-1:0]     data_rdata;
  logic                  data_data_ok;

  logic                  mem_en;
  logic [DATA_W/8-1:0]   mem_wen;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_data_ok;

  modport slave (
    input  inst_req, inst_addr,
    output inst_rdata, inst_data_ok,
    input  data_req, data_wen, data_addr, data_wdata,
    output data_rdata, data_data_ok,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_data_ok
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_rdata, inst_data_ok,
    output data_req, data_wen, data_addr, data_wdata,
    input  data_rdata, data_data_ok,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_data_ok
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between i_cache (read-only) and d_cache (read/write) misses.
// One transaction in flight; data wins unless inst has waited MAX_DATA_BURST data grants.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          streak_reg, streak_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [BE_W-1:0]     wen_reg, wen_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;

  logic grant_d;
  logic grant_i;

  // Data is favoured until it has taken MAX_DATA_BURST grants in front of a waiting fetch.
  assign grant_d = bus.data_req && (!bus.inst_req || (streak_reg < MAX_STREAK));
  assign grant_i = !grant_d && bus.inst_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      streak_reg <= '0;
      addr_reg   <= '0;
      wen_reg    <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
      addr_reg   <= addr_next;
      wen_reg    <= wen_next;
      wdata_reg  <= wdata_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    streak_next      = streak_reg;
    addr_next        = addr_reg;
    wen_next         = wen_reg;
    wdata_next       = wdata_reg;

    bus.mem_en       = 1'b0;
    bus.mem_wen      = '0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.inst_rdata   = '0;
    bus.inst_data_ok = 1'b0;
    bus.data_rdata   = '0;
    bus.data_data_ok = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next = BUSY_D;
          addr_next  = bus.data_addr;
          wen_next   = bus.data_wen;
          wdata_next = bus.data_wdata;
          if (bus.inst_req) begin
            streak_next = (streak_reg >= MAX_STREAK) ? MAX_STREAK : streak_reg + 4'd1;
          end else begin
            streak_next = '0;
          end
        end else if (grant_i) begin
          state_next  = BUSY_I;
          addr_next   = bus.inst_addr;
          wen_next    = '0;
          wdata_next  = '0;
          streak_next = '0;
        end
      end

      BUSY_I: begin
        bus.mem_en       = 1'b1;
        bus.mem_wen      = wen_reg;
        bus.mem_addr     = addr_reg;
        bus.mem_wdata    = wdata_reg;
        bus.inst_rdata   = bus.mem_rdata;
        bus.inst_data_ok = bus.mem_data_ok;
        if (bus.mem_data_ok) begin
          state_next = IDLE;
        end
      end

      BUSY_D: begin
        bus.mem_en       = 1'b1;
        bus.mem_wen      = wen_reg;
        bus.mem_addr     = addr_reg;
        bus.mem_wdata    = wdata_reg;
        bus.data_rdata   = bus.mem_rdata;
        bus.data_data_ok = bus.mem_data_ok;
        if (bus.mem_data_ok) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter, checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory responder controls
  int          mem_lat   = -1;
  bit          mem_hold  = 1'b0;
  bit          stray_en  = 1'b0;
  bit          rd_fix_en = 1'b0;
  logic [31:0] rd_fix    = '0;
  int          mcnt      = 0;
  bit          mactive   = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.mem_data_ok) begin
      bus.mem_data_ok = 1'b0;
      mactive = 1'b0;
    end else if (bus.mem_en) begin
      if (!mem_hold) begin
        if (!mactive) begin
          mactive = 1'b1;
          mcnt = (mem_lat >= 0) ? mem_lat : $urandom_range(0, 3);
        end
        if (mcnt == 0) begin
          bus.mem_data_ok = 1'b1;
          bus.mem_rdata   = rd_fix_en ? rd_fix : $urandom;
        end else begin
          mcnt--;
        end
      end
    end else begin
      mactive = 1'b0;
      if (stray_en && $urandom_range(0, 5) == 0) begin
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = $urandom;
      end
    end
  end

  // transaction-level reference model
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_is_d  = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wen   = '0;
  int          m_streak = 0;

  logic [31:0] grants[$];
  bit          prev_en = 1'b0;
  bit          prev_ok = 1'b0;
  int          inst_ok_cnt = 0;
  int          data_ok_cnt = 0;
  bit          last_i_ok = 1'b0;
  bit          last_d_ok = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mem_en",       bus.mem_en,       m_busy);
      chk("mem_addr",     bus.mem_addr,     m_busy ? m_addr  : 32'h0);
      chk("mem_wen",      bus.mem_wen,      m_busy ? m_wen   : 4'h0);
      chk("mem_wdata",    bus.mem_wdata,    m_busy ? m_wdata : 32'h0);
      chk("inst_data_ok", bus.inst_data_ok, m_busy && !m_is_d && bus.mem_data_ok);
      chk("data_data_ok", bus.data_data_ok, m_busy &&  m_is_d && bus.mem_data_ok);
      if (!(m_busy && !m_is_d)) chk("inst_rdata_idle", bus.inst_rdata, 32'h0);
      else if (bus.mem_data_ok) chk("inst_rdata", bus.inst_rdata, bus.mem_rdata);
      if (!(m_busy && m_is_d)) chk("data_rdata_idle", bus.data_rdata, 32'h0);
      else if (bus.mem_data_ok) chk("data_rdata", bus.data_rdata, bus.mem_rdata);
    end

    if (bus.mem_en && (!prev_en || prev_ok)) grants.push_back(bus.mem_addr);
    if (bus.inst_data_ok) inst_ok_cnt++;
    if (bus.data_data_ok) data_ok_cnt++;
    prev_en   = bus.mem_en;
    prev_ok   = bus.mem_data_ok;
    last_i_ok = bus.inst_data_ok;
    last_d_ok = bus.data_data_ok;

    if (rst) begin
      m_valid  = 1'b1;
      m_busy   = 1'b0;
      m_streak = 0;
      m_addr   = '0;
      m_wen    = '0;
      m_wdata  = '0;
    end else if (m_valid) begin
      if (m_busy) begin
        if (bus.mem_data_ok) m_busy = 1'b0;
      end else if (bus.data_req && (!bus.inst_req || m_streak < MAXB)) begin
        m_busy  = 1'b1;
        m_is_d  = 1'b1;
        m_addr  = bus.data_addr;
        m_wen   = bus.data_wen;
        m_wdata = bus.data_wdata;
        m_streak = bus.inst_req ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 0;
      end else if (bus.inst_req) begin
        m_busy   = 1'b1;
        m_is_d   = 1'b0;
        m_addr   = bus.inst_addr;
        m_wen    = '0;
        m_wdata  = '0;
        m_streak = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ok(input bit is_d, input int limit, output int en_cnt,
                         output logic [31:0] rd, output bit got);
    en_cnt = 0;
    got    = 1'b0;
    rd     = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      if (is_d ? bus.data_data_ok : bus.inst_data_ok) begin
        got = 1'b1;
        rd  = is_d ? bus.data_rdata : bus.inst_rdata;
        break;
      end
    end
    chk(is_d ? "data_ok_timeout" : "inst_ok_timeout", got, 1'b1);
  endtask

  initial begin
    int          en_cnt;
    logic [31:0] rd;
    bit          got;
    int          i0;
    int          d0;
    logic [31:0] exp_order[6];

    bus.inst_req    = 1'b0;
    bus.inst_addr   = '0;
    bus.data_req    = 1'b0;
    bus.data_wen    = '0;
    bus.data_addr   = '0;
    bus.data_wdata  = '0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_mem_en",  bus.mem_en,       1'b0);
    chk("rst_addr",    bus.mem_addr,     32'h0);
    chk("rst_i_ok",    bus.inst_data_ok, 1'b0);
    chk("rst_d_ok",    bus.data_data_ok, 1'b0);

    // single instruction read, memory answers in the third busy cycle
    mem_lat = 2; rd_fix_en = 1'b1; rd_fix = 32'h3C1DBFC0;
    d0 = data_ok_cnt;
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk("i_no_en_cycle0", bus.mem_en, 1'b0);
    @(negedge clk);
    chk("i_en_cycle1", bus.mem_en,   1'b1);
    chk("i_addr",      bus.mem_addr, 32'hBFC00000);
    chk("i_wen",       bus.mem_wen,  4'h0);
    wait_ok(1'b0, 20, en_cnt, rd, got);
    chk("i_en_cycles_after1", en_cnt, 2);
    chk("i_rdata", rd, 32'h3C1DBFC0);
    step();
    bus.inst_req = 1'b0;
    @(negedge clk);
    chk("i_back_idle", bus.mem_en, 1'b0);
    chk("i_no_data_ok", data_ok_cnt, d0);
    rd_fix_en = 1'b0;

    // data write with wdata changing while busy
    mem_lat = 1;
    step();
    bus.data_req = 1'b1; bus.data_wen = 4'b0011;
    bus.data_addr = 32'h80001000; bus.data_wdata = 32'hDEADBEEF;
    @(negedge clk);
    step();
    bus.data_wdata = 32'h12345678;
    d0 = data_ok_cnt;
    @(negedge clk);
    chk("w_wen",   bus.mem_wen,   4'b0011);
    chk("w_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("w_addr",  bus.mem_addr,  32'h80001000);
    wait_ok(1'b1, 20, en_cnt, rd, got);
    step();
    bus.data_req = 1'b0; bus.data_wen = 4'hF;
    @(negedge clk);
    chk("w_one_ok", data_ok_cnt, d0 + 1);
    repeat (3) begin
      @(negedge clk);
      chk("wen_no_req_idle", bus.mem_en, 1'b0);
    end
    step();
    bus.data_wen = 4'h0;

    // contention with single-cycle memory: D D I D D I
    mem_lat = 0;
    grants.delete();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h00001000;
    bus.data_req = 1'b1; bus.data_addr = 32'h00002000; bus.data_wdata = 32'h0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (grants.size() >= 6) break;
    end
    bus.inst_req = 1'b0; bus.data_req = 1'b0;
    chk("c_grant_count", grants.size(), 6);
    exp_order = '{32'h2000, 32'h2000, 32'h1000, 32'h2000, 32'h2000, 32'h1000};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("c_order%0d", i), (i < grants.size()) ? grants[i] : 32'hFFFFFFFF, exp_order[i]);
    end

    // simultaneous first request, data dropped after it is served
    mem_lat = 1;
    step();
    grants.delete();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h00001004;
    bus.data_req = 1'b1; bus.data_addr = 32'h00002004;
    wait_ok(1'b1, 20, en_cnt, rd, got);
    step();
    bus.data_req = 1'b0;
    wait_ok(1'b0, 20, en_cnt, rd, got);
    step();
    bus.inst_req = 1'b0;
    chk("s_first_d",  (grants.size() > 0) ? grants[0] : 32'hFFFFFFFF, 32'h00002004);
    chk("s_second_i", (grants.size() > 1) ? grants[1] : 32'hFFFFFFFF, 32'h00001004);

    // reset while a data write is outstanding, then stray completions
    mem_hold = 1'b1;
    bus.data_req = 1'b1; bus.data_wen = 4'hF;
    bus.data_addr = 32'h80002000; bus.data_wdata = 32'h5;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin got = 1'b1; break; end
    end
    chk("r_busy_seen", got, 1'b1);
    step();
    rst = 1'b1; bus.data_req = 1'b0; bus.data_wen = 4'h0;
    d0 = data_ok_cnt;
    @(negedge clk);
    step();
    rst = 1'b0; mem_hold = 1'b0; stray_en = 1'b1;
    @(negedge clk);
    chk("r_en_low",  bus.mem_en,       1'b0);
    chk("r_no_d_ok", bus.data_data_ok, 1'b0);
    repeat (8) step();
    stray_en = 1'b0;
    chk("r_no_late_ok", data_ok_cnt, d0);

    // abandoned instruction fetch
    mem_lat = 3;
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00010;
    @(negedge clk);
    @(negedge clk);
    chk("a_en", bus.mem_en, 1'b1);
    step();
    bus.inst_req = 1'b0;
    i0 = inst_ok_cnt;
    @(negedge clk);
    chk("a_en_held", bus.mem_en, 1'b1);
    wait_ok(1'b0, 20, en_cnt, rd, got);
    step();
    @(negedge clk);
    chk("a_idle", bus.mem_en, 1'b0);
    chk("a_one_ok", inst_ok_cnt, i0 + 1);

    // randomized traffic
    mem_lat = -1; stray_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      if (bus.inst_req) begin
        if (last_i_ok || $urandom_range(0, 63) == 0) bus.inst_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.inst_req  = 1'b1;
        bus.inst_addr = $urandom & 32'hFFFFFFFC;
      end
      if (bus.data_req) begin
        if (last_d_ok || $urandom_range(0, 63) == 0) bus.data_req = 1'b0;
        else if ($urandom_range(0, 7) == 0) bus.data_wdata = $urandom;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.data_req   = 1'b1;
        bus.data_addr  = $urandom & 32'hFFFFFFFC;
        bus.data_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        bus.data_wdata = $urandom;
      end else begin
        bus.data_wen = 4'($urandom_range(0, 15));
      end
    end
    rst = 1'b0; stray_en = 1'b0;
    bus.inst_req = 1'b0; bus.data_req = 1'b0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the instruction-fetch side and the data side. Requester 0 is the i_cache miss path (read-only); requester 1 is the d_cache miss/write path (read/write).
- Sits between the two caches and the top-level memory interface inside mycpu_top.
- Allows exactly one outstanding transaction on the shared port at a time.
- Data has priority, bounded by a fairness counter so instruction fetch cannot starve.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Byte-enable width is DATA_W/8.
- MAX_DATA_BURST, 2, maximum consecutive data grants while an instruction request is waiting. Legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- inst_req  input  1  instruction read request; held high until inst_data_ok.
- inst_addr  input  ADDR_W  instruction address; stable while inst_req is high.
- inst_rdata  output  DATA_W  read data, valid when inst_data_ok is high.
- inst_data_ok  output  1  one-cycle completion pulse.
- data_req  input  1  data request; held high until data_data_ok.
- data_wen  input  DATA_W/8  byte write enables; 0 means read.
- data_addr  input  ADDR_W  data address.
- data_wdata  input  DATA_W  write data.
- data_rdata  output  DATA_W  read data, valid when data_data_ok is high.
- data_data_ok  output  1  one-cycle completion pulse.
- mem_en  output  1  shared port request; held until mem_data_ok.
- mem_wen  output  DATA_W/8  byte enables to memory.
- mem_addr  output  ADDR_W  address to memory.
- mem_wdata  output  DATA_W  write data to memory.
- mem_rdata  input  DATA_W  memory read data.
- mem_data_ok  input  1  memory completion, variable latency of at least 1 cycle after mem_en.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset (rst=1 at a clock edge):
  - state <= IDLE; data_streak <= 0.
  - Latched address, wen and wdata <= 0.
  - All outputs are 0 in the following cycle.
  - Reset during BUSY aborts the transaction; a late mem_data_ok is ignored because the arbiter is in IDLE.
- IDLE arbitration, evaluated every cycle in IDLE:
  - Grant data if data_req is high and either inst_req is low or data_streak < MAX_DATA_BURST.
  - Otherwise grant inst if inst_req is high.
  - Otherwise stay in IDLE.
- On a grant:
  - Latch addr, wen and wdata from the winner. For inst, wen is 0 and wdata is 0.
  - Go to BUSY_D or BUSY_I.
- data_streak update on a grant:
  - Data grant with inst_req high: data_streak += 1, saturating at MAX_DATA_BURST.
  - Inst grant: data_streak <= 0.
  - Data grant with inst_req low: data_streak <= 0.
- BUSY_x outputs:
  - mem_en = 1; mem_wen, mem_addr and mem_wdata come from the latched registers, so they are stable regardless of requester changes.
- BUSY_x completion:
  - When mem_data_ok = 1: x_data_ok = 1 combinationally and x_rdata = mem_rdata. For writes, rdata is don't-care and must be driven as mem_rdata.
  - Next state is IDLE.
- Latency and throughput:
  - Earliest mem_en is 1 cycle after req is seen in IDLE.
  - Completion is combinational from mem_data_ok.
  - Minimum back-to-back period is 2 cycles per transaction plus memory latency (IDLE → BUSY → IDLE).
- Outside the matching BUSY state:
  - inst_data_ok and data_data_ok are 0.
  - inst_rdata and data_rdata are 0.
  - mem_data_ok arriving in IDLE is ignored.
- Requester deasserting req mid-transaction:
  - The transaction still completes on memory.
  - The data_ok pulse is still issued; the requester ignores it.
- Simultaneous new request and completion: a request arriving in the same cycle as completion is arbitrated in the following IDLE cycle.
- Both requests held continuously with MAX_DATA_BURST=2: grant order is D, D, I, D, D, I, …
- data_wen ≠ 0 with data_req low has no effect.

Test Plan:
- Single inst read: inst_req=1, addr=0xBFC00000; memory responds 3 cycles after mem_en → mem_en high cycles 1–3, mem_addr=0xBFC00000, mem_wen=0; inst_data_ok pulses once with inst_rdata=mem_rdata=0x3C1DBFC0; data_data_ok stays 0.
- Data write: data_req=1, wen=4'b0011, addr=0x80001000, wdata=0xDEADBEEF → mem_wen=4'b0011, mem_wdata=0xDEADBEEF latched; changing data_wdata mid-BUSY does not change mem_wdata; single data_data_ok.
- Contention, MAX_DATA_BURST=2: both reqs held high, 1-cycle memory → grant order D, D, I, D, D, I over 6 transactions; data_streak returns to 0 after each I grant.
- Simultaneous first request: inst_req and data_req rise together in IDLE → data served first; inst served immediately after (streak=1 < 2 gives data priority only if data_req re-asserted; with data_req dropped, I is granted next).
- Reset mid-op: rst=1 during BUSY_D before mem_data_ok → next cycle mem_en=0, state IDLE, no data_ok; a stray mem_data_ok afterwards produces no data_ok pulse.
- Abandoned request: inst_req drops during BUSY_I → mem_en held until mem_data_ok; inst_data_ok still pulses once; arbiter returns to IDLE.
